// File: rtl/inverse_linear_diffusion_iter.sv
// Iterative inverse of the Ascon linear diffusion layer.
// Each word's Sigma is a GF(2) circulant with L^64 = I, so L^-1 = L^63 is the
// product of the six squared maps L^(2^k), k = 0..5. Each squared map is
// again "x ^ ror(x, a) ^ ror(x, b)" with both rotations scaled by 2^k mod 64.
// STEPS_PER_CYCLE of these squared maps are chained per BUSY cycle.
// State layout: word xi occupies state[64*i +: 64] (x0 in the low bits).
module inverse_linear_diffusion_iter #(
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         mode_i,
   input  logic [319:0] state_i,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [319:0] state_o
);

   localparam int S = STEPS_PER_CYCLE;

   // Only divisors of 6 let the step counter land exactly on 6.
   generate
      if (!(S == 1 || S == 2 || S == 3 || S == 6)) begin : g_bad_steps
         $error("STEPS_PER_CYCLE must be 1, 2, 3 or 6");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} fsm_e;

   fsm_e         fsm_q, fsm_d;
   logic [319:0] work_q, work_d;
   logic         mode_q, mode_d;
   logic [2:0]   k_q, k_d;
   logic [319:0] res_q, res_d;

   logic [319:0] work_step;
   logic [2:0]   k_adv;
   logic [3:0]   k_sum;
   logic [3:0]   kk;
   logic         steps_done;

   function automatic logic [5:0] rot_a(input int w);
      case (w)
         0:       return 6'd19;
         1:       return 6'd61;
         2:       return 6'd1;
         3:       return 6'd10;
         default: return 6'd7;
      endcase
   endfunction

   function automatic logic [5:0] rot_b(input int w);
      case (w)
         0:       return 6'd28;
         1:       return 6'd39;
         2:       return 6'd6;
         3:       return 6'd17;
         default: return 6'd41;
      endcase
   endfunction

   // Rotate via a doubled word so an amount of 0 is a plain pass-through.
   function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] amt);
      logic [127:0] dbl;
      dbl = {x, x} >> amt;
      return dbl[63:0];
   endfunction

   // One squared step L^(2^k); the 6-bit result of the shift is the mod 64.
   function automatic logic [63:0] lsq(input logic [63:0] x, input logic [5:0] ra,
                                       input logic [5:0] rb, input logic [2:0] k);
      logic [5:0] a, b;
      a = ra << k;
      b = rb << k;
      return x ^ ror64(x, a) ^ ror64(x, b);
   endfunction

   // Chain S squared steps k_q..k_q+S-1 on all five words; forward mode keeps only k = 0.
   always_comb begin
      work_step = work_q;
      kk        = 4'd0;
      for (int j = 0; j < S; j++) begin
         kk = {1'b0, k_q} + 4'(j);
         if (kk < 4'd6 && (mode_q || j == 0)) begin
            for (int w = 0; w < 5; w++) begin
               work_step[64*w +: 64] = lsq(work_step[64*w +: 64], rot_a(w), rot_b(w), kk[2:0]);
            end
         end
      end
   end

   // Step counter advance, saturating at 6; forward mode is finished after one step.
   always_comb begin
      k_sum = {1'b0, k_q} + 4'(S);
      if (!mode_q)            k_adv = 3'd6;
      else if (k_sum >= 4'd6) k_adv = 3'd6;
      else                    k_adv = k_sum[2:0];
   end

   // k == 6 means every step is applied; that BUSY cycle loads the result register.
   assign steps_done = (k_q == 3'd6);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) fsm_q <= IDLE;
      else     fsm_q <= fsm_d;
   end

   // FSM next state.
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE:    if (in_valid)   fsm_d = BUSY;
         BUSY:    if (steps_done) fsm_d = DONE;
         DONE:    if (out_ready)  fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   // FSM outputs; the result comes straight from a register.
   always_comb begin
      in_ready  = (fsm_q == IDLE);
      out_valid = (fsm_q == DONE);
      state_o   = res_q;
   end

   // Datapath next state: capture in IDLE, iterate in BUSY, publish on entry to DONE.
   always_comb begin
      work_d = work_q;
      mode_d = mode_q;
      k_d    = k_q;
      res_d  = res_q;
      case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               work_d = state_i;
               mode_d = mode_i;
               k_d    = 3'd0;
            end
         end
         BUSY: begin
            if (steps_done) begin
               res_d = work_q;
            end else begin
               work_d = work_step;
               k_d    = k_adv;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         work_q <= '0;
         mode_q <= 1'b0;
         k_q    <= 3'd0;
         res_q  <= '0;
      end else begin
         work_q <= work_d;
         mode_q <= mode_d;
         k_q    <= k_d;
         res_q  <= res_d;
      end
   end

endmodule

// File: tb/tb_inverse_linear_diffusion_iter.sv
// Bench for inverse_linear_diffusion_iter: one instance per legal STEPS_PER_CYCLE,
// all fed the same stimulus, each with its own expected-result queue.
module tb_inverse_linear_diffusion_iter;

   localparam int NL = 4;
   localparam logic [3:0][3:0] SVP = {4'd6, 4'd3, 4'd2, 4'd1};
   localparam int RA[5] = '{19, 61, 1, 10, 7};
   localparam int RB[5] = '{28, 39, 6, 17, 41};

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           mode_i;
   logic           out_ready;
   logic [319:0]   state_i;
   logic [NL-1:0]  in_ready;
   logic [NL-1:0]  out_valid;
   logic [319:0]   state_o [NL];

   int tests = 0;
   int fails = 0;
   int bp_mode = 0;   // 0: always ready, 1: random, 2: held low
   logic [319:0] expq [NL][$];

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < NL; g++) begin : g_dut
         inverse_linear_diffusion_iter #(.STEPS_PER_CYCLE(int'(SVP[g]))) dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready[g]),
            .mode_i   (mode_i),
            .state_i  (state_i),
            .out_valid(out_valid[g]),
            .out_ready(out_ready),
            .state_o  (state_o[g])
         );
      end
   endgenerate

   // ---------------- reference model ----------------
   function automatic logic [63:0] ror(input logic [63:0] x, input int r);
      int m;
      m = r % 64;
      if (m == 0) return x;
      return (x >> m) | (x << (64 - m));
   endfunction

   function automatic logic [319:0] fwd(input logic [319:0] s);
      logic [319:0] o;
      logic [63:0]  x;
      for (int w = 0; w < 5; w++) begin
         x = s[64*w +: 64];
         o[64*w +: 64] = x ^ ror(x, RA[w]) ^ ror(x, RB[w]);
      end
      return o;
   endfunction

   // L^64 = I, so the inverse is the forward map applied 63 times.
   function automatic logic [319:0] inv(input logic [319:0] s);
      logic [319:0] y;
      y = s;
      repeat (63) y = fwd(y);
      return y;
   endfunction

   function automatic logic [319:0] rnd320();
      logic [319:0] r;
      for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic int exp_lat(input int l, input logic m);
      return m ? (6 / int'(SVP[l]) + 1) : 2;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input int lane, input logic [319:0] act, input logic [319:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s lane%0d: got %h expected %h", nm, lane, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting on DUT", nm);
   endtask

   // ---------------- out_ready driver ----------------
   always @(posedge clk) begin
      #1;
      case (bp_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin : mon
      logic [319:0] e;
      if (!rst) begin
         for (int l = 0; l < NL; l++) begin
            if (out_valid[l] && out_ready) begin
               if (expq[l].size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_output lane%0d: got %h expected no output", l, state_o[l]);
               end else begin
                  e = expq[l].pop_front();
                  chk("result", l, state_o[l], e);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   // Wait until every lane is idle, then present one transaction for one edge.
   task automatic issue(input logic [319:0] s, input logic m, input logic [319:0] exp, input bit push);
      int n;
      n = 0;
      while (in_ready !== '1 && n < 300) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 300) timeout("idle_wait");
      if (push) for (int l = 0; l < NL; l++) expq[l].push_back(exp);
      in_valid = 1'b1;
      state_i  = s;
      mode_i   = m;
      @(posedge clk); #2;
      in_valid = 1'b0;
   endtask

   // Count edges from the input handshake until out_valid appears (out_ready held high).
   task automatic measure(input logic m);
      int lat[NL];
      for (int l = 0; l < NL; l++) lat[l] = 0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #2;
         for (int l = 0; l < NL; l++) if (out_valid[l] && lat[l] == 0) lat[l] = c;
      end
      for (int l = 0; l < NL; l++) chk("latency", l, 320'(lat[l]), 320'(exp_lat(l, m)));
   endtask

   initial begin : main
      logic [319:0] x, v, one;
      logic [319:0] held [NL];
      int n, seen;

      rst = 1'b1; in_valid = 1'b0; mode_i = 1'b0; state_i = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      for (int l = 0; l < NL; l++) begin
         chk("rst_in_ready", l, 320'(in_ready[l]), 320'd1);
         chk("rst_out_valid", l, 320'(out_valid[l]), 320'd0);
         chk("rst_state_o", l, state_o[l], 320'd0);
      end
      rst = 1'b0;
      @(posedge clk); #2;

      // zero state, inverse
      issue(320'd0, 1'b1, 320'd0, 1'b1);
      measure(1'b1);

      // forward single bit in x0
      issue(320'h1, 1'b0, 320'h0000_2010_0000_0001, 1'b1);
      measure(1'b0);

      // inverse single bit in x0, then in each other word
      issue(320'h0000_2010_0000_0001, 1'b1, 320'h1, 1'b1);
      measure(1'b1);
      for (int w = 1; w < 5; w++) begin
         one = 320'h1 << (64 * w);
         issue(fwd(one), 1'b1, one, 1'b1);
         measure(1'b1);
      end

      // backpressure hold with an ignored input pulse
      bp_mode = 2;
      @(posedge clk); #2;
      x = rnd320();
      issue(x, 1'b1, inv(x), 1'b1);
      n = 0;
      while (out_valid !== '1 && n < 20) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 20) timeout("bp_out_valid");
      for (int l = 0; l < NL; l++) held[l] = state_o[l];
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #2;
         in_valid = (c == 3);
         state_i  = rnd320();
         mode_i   = 1'b1;
         for (int l = 0; l < NL; l++) begin
            chk("bp_out_valid", l, 320'(out_valid[l]), 320'd1);
            chk("bp_in_ready", l, 320'(in_ready[l]), 320'd0);
            chk("bp_state_stable", l, state_o[l], held[l]);
         end
      end
      in_valid = 1'b0;
      bp_mode = 0;
      @(posedge clk); #2;
      @(posedge clk); #2;
      for (int l = 0; l < NL; l++) begin
         chk("release_in_ready", l, 320'(in_ready[l]), 320'd1);
         chk("release_out_valid", l, 320'(out_valid[l]), 320'd0);
      end

      // reset at the third BUSY edge; nothing may be emitted
      bp_mode = 2;
      @(posedge clk); #2;
      issue(rnd320(), 1'b1, 320'd0, 1'b0);
      seen = 0;
      for (int c = 1; c <= 2; c++) begin
         @(posedge clk); #2;
         if (out_valid[0] || out_valid[1]) seen++;
      end
      chk("pre_rst_no_valid", 0, 320'(seen), 320'd0);
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      bp_mode = 0;
      for (int l = 0; l < NL; l++) begin
         chk("post_rst_in_ready", l, 320'(in_ready[l]), 320'd1);
         chk("post_rst_out_valid", l, 320'(out_valid[l]), 320'd0);
      end
      seen = 0;
      repeat (10) begin
         @(posedge clk); #2;
         if (out_valid != '0) seen++;
      end
      chk("post_rst_no_emit", 0, 320'(seen), 320'd0);
      x = rnd320();
      issue(x, 1'b1, inv(x), 1'b1);
      measure(1'b1);

      // randomized round trips under random backpressure
      bp_mode = 1;
      for (int i = 0; i < 500; i++) begin
         x = rnd320();
         if (i % 2 == 0) begin
            v = fwd(x);
            issue(v, 1'b1, x, 1'b1);
         end else begin
            v = inv(x);
            issue(v, 1'b0, x, 1'b1);
         end
      end

      // drain
      bp_mode = 0;
      n = 0;
      while ((expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()) != 0 && n < 300) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 300) timeout("drain");
      for (int l = 0; l < NL; l++) chk("queue_empty", l, 320'(expq[l].size()), 320'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
